// File: rtl/latch_write_arbiter_pkg.sv
// Shared types and defaults for the latch write arbiter.
// State encoding is fixed so the bank sequencing is easy to follow in waves.
package latch_write_arbiter_pkg;

    localparam int N_REQ_DEF       = 4;
    localparam int WIDTH_DEF       = 8;
    localparam int HOLD_CYCLES_DEF = 1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_PULSE = 3'd2,
        ST_HOLD  = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

endpackage

// File: rtl/latch_write_arbiter_if.sv
// Requester/bank bundle: requests and data in, acks and latch drive out.
// The master side is the requesters (and bank observer), the slave side is the arbiter.
interface latch_write_arbiter_if
    import latch_write_arbiter_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int WIDTH = WIDTH_DEF
);
    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0]       req;
    logic [N_REQ*WIDTH-1:0] wdata;
    logic [N_REQ-1:0]       ack;
    logic [IW-1:0]          grant_id;
    logic                   lat_en;
    logic [WIDTH-1:0]       lat_d;
    logic                   busy;

    modport master (
        output req, wdata,
        input  ack, grant_id, lat_en, lat_d, busy
    );

    modport slave (
        input  req, wdata,
        output ack, grant_id, lat_en, lat_d, busy
    );

endinterface

// File: rtl/latch_write_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or above ptr_i, wrapping.
// Zero latency; vld_o low when no request is pending.
module rr_arbiter
    import latch_write_arbiter_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int IW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IW-1:0]    ptr_i,
    output logic             vld_o,
    output logic [IW-1:0]    win_o
);

    int unsigned idx;

    // Scan from the farthest offset down so the nearest request overwrites last.
    always_comb begin
        vld_o = 1'b0;
        win_o = '0;
        idx   = 0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = (int'(ptr_i) + k) % N_REQ;
            if (req_i[idx]) begin
                vld_o = 1'b1;
                win_o = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/latch_write_arbiter.sv
// Shares one latch bank between requesters: setup, one-cycle En pulse, hold, then ack; HOLD_CYCLES+3 cycles busy.
// No backpressure on the bank; requesters wait on req until their one-cycle ack pulse.
module latch_write_arbiter
    import latch_write_arbiter_pkg::*;
#(
    parameter int N_REQ       = N_REQ_DEF,
    parameter int WIDTH       = WIDTH_DEF,
    parameter int HOLD_CYCLES = HOLD_CYCLES_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    latch_write_arbiter_if.slave  bus
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    state_e           state_q, state_d;
    logic [IW-1:0]    ptr_q,   ptr_d;
    logic [IW-1:0]    gid_q,   gid_d;
    logic [CW-1:0]    cnt_q,   cnt_d;
    logic [WIDTH-1:0] dat_q,   dat_d;
    logic [N_REQ-1:0] ack_q,   ack_d;
    logic             en_q,    en_d;
    logic             busy_q,  busy_d;

    logic             arb_vld;
    logic [IW-1:0]    arb_win;

    rr_arbiter #(.N_REQ(N_REQ), .IW(IW)) u_rr (
        .req_i (bus.req),
        .ptr_i (ptr_q),
        .vld_o (arb_vld),
        .win_o (arb_win)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            gid_q   <= '0;
            cnt_q   <= '0;
            dat_q   <= '0;
            ack_q   <= '0;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gid_q   <= gid_d;
            cnt_q   <= cnt_d;
            dat_q   <= dat_d;
            ack_q   <= ack_d;
            en_q    <= en_d;
            busy_q  <= busy_d;
        end
    end

    // Outputs are registered, so each is set on the edge entering the state it belongs to.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gid_d   = gid_q;
        cnt_d   = cnt_q;
        dat_d   = dat_q;
        ack_d   = '0;
        en_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (arb_vld) begin
                    state_d = ST_SETUP;
                    gid_d   = arb_win;
                    dat_d   = bus.wdata[int'(arb_win)*WIDTH +: WIDTH];
                end
            end
            ST_SETUP: begin
                state_d = ST_PULSE;
                en_d    = 1'b1;
            end
            ST_PULSE: begin
                state_d = ST_HOLD;
                cnt_d   = CW'(HOLD_CYCLES - 1);
            end
            ST_HOLD: begin
                if (cnt_q == '0) begin
                    state_d       = ST_DONE;
                    ack_d[gid_q]  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                ptr_d   = (gid_q == IW'(N_REQ - 1)) ? '0 : gid_q + 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    assign bus.ack      = ack_q;
    assign bus.grant_id = gid_q;
    assign bus.lat_en   = en_q;
    assign bus.lat_d    = dat_q;
    assign bus.busy     = busy_q;

endmodule

// File: tb/tb_latch_write_arbiter.sv
// Bench for latch_write_arbiter: directed scenarios plus random traffic against a transaction-timing model.
module tb_latch_write_arbiter;

    localparam int N    = 4;
    localparam int W    = 8;
    localparam int HOLD = 1;
    localparam int OCC  = HOLD + 3;

    logic clk;
    logic rst_n;

    latch_write_arbiter_if #(.N_REQ(N), .WIDTH(W)) bus ();

    latch_write_arbiter #(.N_REQ(N), .WIDTH(W), .HOLD_CYCLES(HOLD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Storage bank behaviour: transparent while En is high.
    logic [W-1:0] bank_q;
    initial bank_q = '0;
    always @(bus.lat_en or bus.lat_d) if (bus.lat_en) bank_q = bus.lat_d;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int rr_pick(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++)
            if (r[(p + k) % N]) return (p + k) % N;
        return 0;
    endfunction

    // Model: m_t is the cycle offset from the accepting edge E0, -1 when idle.
    int           m_t;
    int           m_ptr;
    int           m_gid;
    logic [W-1:0] m_data;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_t    <= -1;
            m_ptr  <= 0;
            m_gid  <= 0;
            m_data <= '0;
        end else if (m_t == -1) begin
            if (|bus.req) begin
                m_t    <= 1;
                m_gid  <= rr_pick(bus.req, m_ptr);
                m_data <= bus.wdata[rr_pick(bus.req, m_ptr)*W +: W];
            end
        end else if (m_t == OCC) begin
            m_t   <= -1;
            m_ptr <= (m_gid + 1) % N;
        end else begin
            m_t <= m_t + 1;
        end
    end

    logic [N-1:0] keep_mask;

    // One cycle: compare against the model at the falling edge, then drop acked requests.
    task automatic tick();
        logic [N-1:0] exp_ack;
        @(negedge clk);
        if (rst_n) begin
            exp_ack = (m_t == OCC) ? (N'(1) << m_gid) : '0;
            chk("busy",     32'(bus.busy),     32'(m_t >= 1));
            chk("lat_en",   32'(bus.lat_en),   32'(m_t == 2));
            chk("ack",      32'(bus.ack),      32'(exp_ack));
            chk("grant_id", 32'(bus.grant_id), 32'(m_gid));
            chk("lat_d",    32'(bus.lat_d),    32'(m_data));
            if (exp_ack != '0) chk("bank_q", 32'(bank_q), 32'(m_data));
        end
        bus.req = bus.req & ~(bus.ack & ~keep_mask);
    endtask

    initial begin
        int           n;
        int           cyc;
        int           ack_cyc [4];
        logic [N-1:0] ack_v   [4];
        logic [W-1:0] bank_v  [4];
        bit           seen_en;

        keep_mask = '0;
        rst_n     = 1'b0;
        bus.req   = N'($urandom);
        bus.wdata = {$urandom, $urandom};

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_lat_en",   32'(bus.lat_en),   0);
        chk("rst_lat_d",    32'(bus.lat_d),    0);
        chk("rst_ack",      32'(bus.ack),      0);
        chk("rst_grant_id", 32'(bus.grant_id), 0);
        chk("rst_busy",     32'(bus.busy),     0);
        bus.req = '0;
        rst_n   = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("idle_busy", 32'(bus.busy), 0);
        end

        // Contention: all four at once, served 0,1,2,3 with 5-cycle spacing
        bus.req   = 4'b1111;
        bus.wdata = 32'h44332211;
        n   = 0;
        cyc = 0;
        while (n < 4 && cyc < 60) begin
            tick();
            cyc++;
            if (bus.ack != '0) begin
                ack_v[n]   = bus.ack;
                ack_cyc[n] = cyc;
                bank_v[n]  = bank_q;
                n++;
            end
        end
        chk("cont_count", 32'(n), 4);
        for (int k = 0; k < 4; k++) begin
            if (k < n) begin
                chk("cont_ack_order", 32'(ack_v[k]), 32'(1) << k);
                chk("cont_bank", 32'(bank_v[k]), 32'(8'h11 * (k + 1)));
                if (k > 0) chk("cont_spacing", 32'(ack_cyc[k] - ack_cyc[k-1]), HOLD + 4);
            end
        end

        // Fairness: requesters 0 and 3 keep asking
        keep_mask = 4'b1001;
        bus.req   = 4'b1001;
        n   = 0;
        cyc = 0;
        while (n < 8 && cyc < 100) begin
            tick();
            cyc++;
            if (bus.ack != '0) begin
                chk("fair_grant", 32'(bus.grant_id), (n % 2 == 0) ? 0 : 3);
                n++;
            end
        end
        chk("fair_count", 32'(n), 8);
        keep_mask = '0;
        bus.req   = '0;
        tick();

        // Single write: requester 2, A5
        bus.req = 4'b0100;
        bus.wdata[2*W +: W] = 8'hA5;
        tick();
        chk("sw_lat_d_e1", 32'(bus.lat_d), 32'hA5);
        chk("sw_en_e1",    32'(bus.lat_en), 0);
        tick();
        chk("sw_en_e2",    32'(bus.lat_en), 1);
        tick();
        chk("sw_en_e3",    32'(bus.lat_en), 0);
        tick();
        chk("sw_ack_e4",   32'(bus.ack), 32'h4);
        tick();
        chk("sw_busy_e5",  32'(bus.busy), 0);
        chk("sw_bank",     32'(bank_q), 32'hA5);

        // wdata change and req withdrawal after the grant are ignored
        bus.req = 4'b0010;
        bus.wdata[1*W +: W] = 8'h3C;
        tick();
        tick();
        bus.wdata[1*W +: W] = 8'hFF;
        bus.req[1] = 1'b0;
        tick();
        tick();
        chk("stab_ack", 32'(bus.ack), 32'h2);
        tick();
        chk("stab_bank", 32'(bank_q), 32'h3C);

        // Asynchronous reset while En is high
        bus.req = 4'b0100;
        seen_en = 1'b0;
        for (int i = 0; i < 10 && !seen_en; i++) begin
            tick();
            seen_en = bus.lat_en;
        end
        chk("mid_saw_en", 32'(seen_en), 1);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_lat_en", 32'(bus.lat_en), 0);
        chk("mid_ack",    32'(bus.ack),    0);
        chk("mid_lat_d",  32'(bus.lat_d),  0);
        chk("mid_busy",   32'(bus.busy),   0);
        bus.req = '0;
        tick();
        tick();
        rst_n   = 1'b1;
        bus.req = 4'b1001;
        tick();
        chk("post_rst_grant", 32'(bus.grant_id), 0);
        for (int i = 0; i < 12; i++) tick();
        bus.req = '0;
        for (int i = 0; i < 8; i++) tick();

        // Random traffic; requests are held until acked unless occasionally withdrawn
        for (int c = 0; c < 500; c++) begin
            tick();
            for (int i = 0; i < N; i++) begin
                if (!bus.req[i] && $urandom_range(3) == 0) begin
                    bus.req[i] = 1'b1;
                    bus.wdata[i*W +: W] = W'($urandom);
                end
            end
            if ($urandom_range(7) == 0) bus.wdata[$urandom_range(N-1)*W +: W] = W'($urandom);
            if ($urandom_range(31) == 0) bus.req[$urandom_range(N-1)] = 1'b0;
        end
        bus.req = '0;
        for (int i = 0; i < 10; i++) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
